// File: rtl/qadd_sm.sv
// qadd_sm: sign-magnitude fixed-point adder with a registered result.
//
// The word is N bits wide with Q fractional bits. Bit N-1 is the sign and
// bits [N-2:0] are the magnitude. Both operands share Q, so their binary
// points already line up and Q does not enter the arithmetic.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   a/b are valid this cycle
//   a, b      in   N-bit sign-magnitude operands
//   c         out  registered sum, loaded when in_valid is high
//   out_valid out  c/overflow were loaded on the last edge
//   overflow  out  magnitude carry-out for the result held in c
//
// Optional build macro QADD_SATURATE_EN: when defined, an overflowing
// magnitude clamps to all ones and keeps the operand sign. When undefined,
// the carry is dropped and the magnitude wraps.
module qadd_sm #(
    parameter int Q = 23,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic         out_valid,
    output logic         overflow
);

    localparam int MW = N - 1;

    // Q only documents the format; it is not used by the arithmetic.
    localparam int QF = Q;

    logic [N-1:0]  c_d, c_q;
    logic          out_valid_d, out_valid_q;
    logic          overflow_d, overflow_q;

    logic          sa, sb;
    logic [MW-1:0] ma, mb;
    logic [N-1:0]  sum_same;
    logic          a_ge_b;
    logic [MW-1:0] res_mag;
    logic          res_sign;
    logic          res_ovf;

    always_comb begin
        sa       = a[N-1];
        sb       = b[N-1];
        ma       = a[MW-1:0];
        mb       = b[MW-1:0];
        sum_same = {1'b0, ma} + {1'b0, mb};
        a_ge_b   = (ma >= mb);

        res_mag  = '0;
        res_sign = 1'b0;
        res_ovf  = 1'b0;

        if (sa == sb) begin
            res_sign = sa;
            res_ovf  = sum_same[N-1];
`ifdef QADD_SATURATE_EN
            res_mag  = sum_same[N-1] ? {MW{1'b1}} : sum_same[MW-1:0];
`else
            res_mag  = sum_same[MW-1:0];
`endif
        end else if (a_ge_b) begin
            res_sign = sa;
            res_mag  = ma - mb;
        end else begin
            res_sign = sb;
            res_mag  = mb - ma;
        end

        // Any zero magnitude is reported as +0. This covers x + (-x), -0
        // operands and a wrapped overflow that lands on zero.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end

        // c and overflow hold their values on idle cycles. out_valid drops.
        c_d         = c_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            c_d        = {res_sign, res_mag};
            overflow_d = res_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_qadd_sm.sv
// tb_qadd_sm: directed, table-driven bench for qadd_sm (Q=23, N=32).
// Inputs change on the falling edge. Outputs are sampled on the next
// falling edge, which is half a cycle after the edge that loaded them.
module tb_qadd_sm;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        out_valid;
    logic        overflow;

    int total;
    int bad;

    qadd_sm #(.Q(23), .N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_c;
        logic        exp_ov;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] ec, input logic ev, input logic eo);
        check({name, ".c"}, c, ec);
        check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({name, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    initial begin
`ifdef QADD_SATURATE_EN
        localparam logic [31:0] OVP = 32'h7FFFFFFF;
        localparam logic [31:0] OVN = 32'hFFFFFFFF;
`else
        localparam logic [31:0] OVP = 32'h00000000;
        localparam logic [31:0] OVN = 32'h00000000;
`endif
        total = 0;
        bad   = 0;

        vecs[0]  = '{32'h00800000, 32'h00800000, 32'h01000000, 1'b0}; // 1.0+1.0
        vecs[1]  = '{32'h80800000, 32'h80400000, 32'h80C00000, 1'b0}; // -1.0-0.5
        vecs[2]  = '{32'h00800000, 32'h80400000, 32'h00400000, 1'b0}; // 1.0-0.5
        vecs[3]  = '{32'h80800000, 32'h00400000, 32'h80400000, 1'b0}; // -1.0+0.5
        vecs[4]  = '{32'h00800000, 32'h80800000, 32'h00000000, 1'b0}; // cancel
        vecs[5]  = '{32'h80000000, 32'h80000000, 32'h00000000, 1'b0}; // -0 + -0
        vecs[6]  = '{32'h7FFFFFFF, 32'h00000001, OVP,          1'b1}; // ovf +
        vecs[7]  = '{32'hFFFFFFFF, 32'h80000001, OVN,          1'b1}; // ovf -
        vecs[8]  = '{32'h00400000, 32'h80800000, 32'h80400000, 1'b0}; // |b|>|a|
        vecs[9]  = '{32'h80000000, 32'h00000005, 32'h00000005, 1'b0}; // -0 + 5
        vecs[10] = '{32'h40000000, 32'h40000000, OVP,          1'b1}; // ovf wraps to 0
        vecs[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}; // max cancel
        vecs[12] = '{32'h00000003, 32'h80000005, 32'h80000002, 1'b0}; // 3-5

        // Reset state and idle hold.
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #12;
        check_out("reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_out("idle_after_reset", 32'h0, 1'b0, 1'b0);
        end

        // Table: one vector per valid cycle, each followed by an idle cycle.
        // On the idle cycle c and overflow must hold and out_valid must drop.
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            @(negedge clk);
            in_valid = 1'b0;
            a        = 32'h12345678;
            b        = 32'h0ABCDEF0;
            check_out($sformatf("vec%0d", i), vecs[i].exp_c, 1'b1, vecs[i].exp_ov);
            @(negedge clk);
            check_out($sformatf("hold%0d", i), vecs[i].exp_c, 1'b0, vecs[i].exp_ov);
        end

        // Back-to-back: four pairs on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            @(negedge clk);
            check_out($sformatf("b2b%0d", i), vecs[i].exp_c, 1'b1, vecs[i].exp_ov);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check_out("b2b_hold", vecs[3].exp_c, 1'b0, 1'b0);

        // Load an overflow result so that reset has nonzero state to clear.
        in_valid = 1'b1;
        a        = vecs[10].a;
        b        = vecs[10].b;
        @(negedge clk);
        // Present a new pair, then assert reset mid-cycle before the edge.
        a = vecs[0].a;
        b = vecs[0].b;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 32'h0, 1'b0, 1'b0);
        // The in-flight pair must be discarded while reset is held.
        @(posedge clk);
        #1;
        check_out("reset_held", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_out("post_reset_idle", 32'h0, 1'b0, 1'b0);

        // The adder works again after reset.
        in_valid = 1'b1;
        a        = vecs[12].a;
        b        = vecs[12].b;
        @(negedge clk);
        in_valid = 1'b0;
        check_out("post_reset_vec", vecs[12].exp_c, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qadd_sm.md
Name: qadd_sm

Overview:
- Parameterised sign-magnitude fixed-point adder, Q-format with Q fractional bits in an N-bit word.
- Sits in the arithmetic datapath next to the multiply and divide units; the top-level opcode mux selects its result for the Add operation.
- Adds two operands and registers the sum.
- Valid strobe in, valid strobe plus overflow flag out.

Parameters:
- Q, 23, number of fractional bits. Bits [Q-1:0] are the fraction.
- N, 32, total word width. Bit N-1 is the sign; bits [N-2:0] are the magnitude.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a/b are valid this cycle.
- a  input  N  operand A, sign-magnitude Q(N-1-Q).Q.
- b  input  N  operand B, same format.
- c  output  N  registered sum, same format.
- out_valid  output  1  c and overflow are updated this cycle.
- overflow  output  1  magnitude carry-out occurred for the result in c.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: c = 0, out_valid = 0, overflow = 0. Reset asserted mid-operation clears all outputs immediately; the sample in flight is discarded.
- Latency is 1 cycle. When in_valid=1 at a rising edge, c and overflow load the result for that a/b and out_valid=1 on the following cycle.
- When in_valid=0 at a rising edge: out_valid=0, and c and overflow hold their previous values.
- No backpressure. A new operand pair is accepted every cycle.
- Let sa/sb be the signs and ma/mb the (N-1)-bit magnitudes.
- Equal signs:
  - sum = ma + mb computed N bits wide.
  - Result sign = sa; result magnitude = sum[N-2:0]; overflow = sum[N-1].
- Different signs:
  - If ma >= mb: magnitude = ma - mb, sign = sa. Otherwise magnitude = mb - ma, sign = sb.
  - overflow = 0.
- Zero normalisation: a zero result magnitude always produces +0 (sign 0), including from x + (-x).
- Negative-zero inputs (sign 1, magnitude 0) are treated as +0.
- The integer/fraction split does not affect the arithmetic. Binary points align because both operands share Q.
- No rounding; the operation is exact except for magnitude overflow.

Optional Feature:
- Macro QADD_SATURATE_EN.
- Defined: on overflow, the result magnitude saturates to all ones (2^(N-1)-1) with the sign of the operands. overflow is still asserted.
- Undefined: on overflow, the carry is dropped and the magnitude wraps (low N-1 bits kept). overflow is asserted.
- Non-overflow results are identical in both builds.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle -> c=0x00000000, out_valid=0, overflow=0 immediately. Release, then in_valid=0 for 3 cycles -> outputs unchanged.
- Same signs: a=0x00800000 (1.0), b=0x00800000, in_valid=1 -> next cycle c=0x01000000 (2.0), out_valid=1, overflow=0. With a=0x80800000, b=0x80400000 -> c=0x80C00000 (-1.5).
- Mixed signs: a=0x00800000 (1.0), b=0x80400000 (-0.5) -> c=0x00400000. Swapping to a=0x80800000, b=0x00400000 -> c=0x80400000 (-0.5).
- Cancellation: a=0x00800000, b=0x80800000 -> c=0x00000000 (positive zero), overflow=0. Also a=0x80000000, b=0x80000000 -> c=0x00000000.
- Overflow: a=0x7FFFFFFF, b=0x00000001 -> overflow=1.
  - Without the macro: c=0x00000000.
  - With QADD_SATURATE_EN: c=0x7FFFFFFF.
  - With a=0xFFFFFFFF, b=0x80000001 and the macro: c=0xFFFFFFFF.
- Throughput and hold: back-to-back in_valid for 4 pairs -> 4 consecutive out_valid cycles, each c matching its pair one cycle later. Then in_valid=0 -> out_valid=0 and c holds the last sum.
